// File: rtl/mpi_reg_slave.sv
// mpi_reg_slave: two-register slave on the inverted, multiplexed MPI bus.
//
// Ports:
//   CLKp      bus clock, all state changes on the rising edge
//   nRSTp     asynchronous active-low reset
//   nADp      inverted address/data; driven only while replying to a read
//   nSYNCp    active-low address strobe
//   nDINp     active-low read strobe
//   nDOUTp    active-low write strobe
//   nWTBTp    active-low byte-write flag, sampled with the write data
//   nRPLYp    open-drain reply (0 or z)
//   port_in   value returned when PORT is read
//   port_out  PORT register contents
//   port_wr   one-cycle pulse when PORT has just been written
//   sys_out   SYS register contents
//
// Build option: define MPI_SLAVE_WAIT_EN to insert WAIT_CYCLES extra clocks
// (state DLY) between strobe detection and the reply.
module mpi_reg_slave #(
  parameter logic [15:0] ADDR_PORT   = 16'o177714,
  parameter logic [15:0] ADDR_SYS    = 16'o177716,
  parameter logic [15:0] SYS_WMASK   = 16'hFFF0,
  parameter logic [15:0] SYS_RESET   = 16'h0000,
  parameter int          WAIT_CYCLES = 2
) (
  input  logic        CLKp,
  input  logic        nRSTp,
  inout  logic [15:0] nADp,
  input  logic        nSYNCp,
  input  logic        nDINp,
  input  logic        nDOUTp,
  input  logic        nWTBTp,
  output logic        nRPLYp,
  input  logic [15:0] port_in,
  output logic [15:0] port_out,
  output logic        port_wr,
  output logic [15:0] sys_out
);
  typedef enum logic [2:0] {IDLE, ADDR, WAITSTB, DLY, REPLY, DONE} state_t;
`ifdef MPI_SLAVE_WAIT_EN
  localparam bit WAIT_EN = WAIT_CYCLES > 0;
  localparam int CW = WAIT_CYCLES > 0 ? $clog2(WAIT_CYCLES + 1) : 1;
  logic [CW-1:0] cnt_q, cnt_d;
`else
  localparam bit WAIT_EN = 1'b0 && (WAIT_CYCLES > 0);
`endif
  state_t      state_q, state_d;
  logic        sync_q;
  logic [15:0] addr_q, addr_d;
  logic        sel_port_q, sel_port_d;
  logic [15:0] rdata_q, rdata_d;
  logic [15:0] wdata_q, wdata_d;
  logic        bw_q, bw_d;
  logic        rd_q, rd_d;
  logic        rply_q, rply_d;
  logic        oe_q, oe_d;
  logic [15:0] port_q, port_d;
  logic [15:0] sys_q, sys_d;
  logic        port_wr_q, port_wr_d;
  logic        hit_port, hit_sys, strobe;
  logic [15:0] cur, wmerge;
  assign hit_port = addr_q[15:1] == ADDR_PORT[15:1];
  assign hit_sys  = addr_q[15:1] == ADDR_SYS[15:1];
  assign strobe   = !nDINp || !nDOUTp;
  // Byte writes replace only the lane picked by the address LSB.
  assign cur    = sel_port_q ? port_q : sys_q;
  assign wmerge = !bw_q ? wdata_q :
                  addr_q[0] ? {wdata_q[15:8], cur[7:0]} : {cur[15:8], wdata_q[7:0]};
  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    sel_port_d = sel_port_q;
    rdata_d    = rdata_q;
    wdata_d    = wdata_q;
    bw_d       = bw_q;
    rd_d       = rd_q;
    rply_d     = rply_q;
    oe_d       = oe_q;
    port_d     = port_q;
    sys_d      = sys_q;
    port_wr_d  = 1'b0;
`ifdef MPI_SLAVE_WAIT_EN
    cnt_d      = cnt_q;
`endif
    // nSYNC high outside IDLE ends the cycle and drops anything not yet committed.
    if (state_q != IDLE && nSYNCp) begin
      state_d = IDLE;
      rply_d  = 1'b0;
      oe_d    = 1'b0;
    end else begin
      case (state_q)
        IDLE: if (sync_q && !nSYNCp) begin
          addr_d  = ~nADp;
          state_d = ADDR;
        end
        ADDR: begin
          sel_port_d = hit_port;
          state_d    = (hit_port || hit_sys) ? WAITSTB : DONE;
        end
        WAITSTB: if (strobe) begin
          // Both strobes low together is served as a read.
          rd_d    = !nDINp;
          rdata_d = sel_port_q ? port_in : sys_q;
          wdata_d = ~nADp;
          bw_d    = !nWTBTp;
          state_d = WAIT_EN ? DLY : REPLY;
`ifdef MPI_SLAVE_WAIT_EN
          cnt_d   = '0;
`endif
        end
`ifdef MPI_SLAVE_WAIT_EN
        DLY: begin
          if (!strobe) state_d = DONE;
          else if (cnt_q == CW'(WAIT_CYCLES - 1)) state_d = REPLY;
          else cnt_d = cnt_q + CW'(1);
        end
`endif
        // First REPLY edge asserts the reply and commits; later edges wait for strobe release.
        REPLY: if (!rply_q) begin
          rply_d = 1'b1;
          oe_d   = rd_q;
          if (!rd_q && sel_port_q) begin
            port_d    = wmerge;
            port_wr_d = 1'b1;
          end
          if (!rd_q && !sel_port_q) sys_d = (sys_q & ~SYS_WMASK) | (wmerge & SYS_WMASK);
        end else if (!strobe) begin
          rply_d  = 1'b0;
          oe_d    = 1'b0;
          state_d = DONE;
        end
        DONE: state_d = DONE;
        default: state_d = IDLE;
      endcase
    end
  end
  // sync_q resets low so a cycle already under way at reset release is not picked up.
  always_ff @(posedge CLKp or negedge nRSTp) begin
    if (!nRSTp) begin
      state_q    <= IDLE;
      sync_q     <= 1'b0;
      addr_q     <= '0;
      sel_port_q <= 1'b0;
      rdata_q    <= '0;
      wdata_q    <= '0;
      bw_q       <= 1'b0;
      rd_q       <= 1'b0;
      rply_q     <= 1'b0;
      oe_q       <= 1'b0;
      port_q     <= '0;
      sys_q      <= SYS_RESET;
      port_wr_q  <= 1'b0;
`ifdef MPI_SLAVE_WAIT_EN
      cnt_q      <= '0;
`endif
    end else begin
      state_q    <= state_d;
      sync_q     <= nSYNCp;
      addr_q     <= addr_d;
      sel_port_q <= sel_port_d;
      rdata_q    <= rdata_d;
      wdata_q    <= wdata_d;
      bw_q       <= bw_d;
      rd_q       <= rd_d;
      rply_q     <= rply_d;
      oe_q       <= oe_d;
      port_q     <= port_d;
      sys_q      <= sys_d;
      port_wr_q  <= port_wr_d;
`ifdef MPI_SLAVE_WAIT_EN
      cnt_q      <= cnt_d;
`endif
    end
  end
  assign nRPLYp   = rply_q ? 1'b0 : 1'bz;
  assign nADp     = oe_q ? ~rdata_q : 16'hzzzz;
  assign port_out = port_q;
  assign port_wr  = port_wr_q;
  assign sys_out  = sys_q;
endmodule

// File: tb/tb_mpi_reg_slave.sv
// tb_mpi_reg_slave: randomized and directed bus cycles against a register model.
module tb_mpi_reg_slave;
  localparam logic [15:0] A_PORT = 16'o177714;
  localparam logic [15:0] A_SYS  = 16'o177716;
  localparam logic [15:0] MASK   = 16'hFFF0;
  localparam logic [15:0] SRST   = 16'h0000;
  localparam int          WAIT   = 2;
`ifdef MPI_SLAVE_WAIT_EN
  localparam int LAT = 2 + WAIT;
`else
  localparam int LAT = 2;
`endif
  logic        clk = 1'b0;
  logic        nrst = 1'b0;
  logic        nsync = 1'b1, ndin = 1'b1, ndout = 1'b1, nwtbt = 1'b1;
  logic [15:0] m_ad = 16'hFFFF;
  logic        m_oe = 1'b0;
  logic [15:0] port_in = 16'h0000;
  wire  [15:0] nad;
  wire         nrply;
  wire  [15:0] port_out, sys_out;
  wire         port_wr;
  logic [15:0] port_m = 16'h0000, sys_m = SRST;
  int          n_checks = 0, n_fail = 0, pulse_cnt = 0;
  assign nad = m_oe ? m_ad : 16'hzzzz;
  pullup (nrply);
  for (genvar i = 0; i < 16; i++) begin : g_pu
    pullup (nad[i]);
  end
  mpi_reg_slave #(
    .ADDR_PORT(A_PORT), .ADDR_SYS(A_SYS), .SYS_WMASK(MASK), .SYS_RESET(SRST), .WAIT_CYCLES(WAIT)
  ) dut (
    .CLKp(clk), .nRSTp(nrst), .nADp(nad), .nSYNCp(nsync), .nDINp(ndin), .nDOUTp(ndout),
    .nWTBTp(nwtbt), .nRPLYp(nrply), .port_in(port_in), .port_out(port_out), .port_wr(port_wr),
    .sys_out(sys_out)
  );
  always #5 clk = ~clk;
  always @(negedge clk) if (port_wr === 1'b1) pulse_cnt++;
  function automatic logic [15:0] merge(logic [15:0] old, logic odd, logic bw, logic [15:0] w);
    if (!bw) return w;
    return odd ? {w[15:8], old[7:0]} : {old[15:8], w[7:0]};
  endfunction
  // op: 0 read, 1 write, 2 both strobes together. lat = -1 when no reply was seen.
  task automatic bus_cycle(input logic [15:0] addr, input int op, input logic bw, input logic [15:0] wd,
                           output int lat, output logic [15:0] rd, output int pulses,
                           output logic rel, output logic drove);
    lat = -1; rd = 16'hxxxx; rel = 1'b0; drove = 1'b0;
    @(negedge clk);
    pulse_cnt = 0; m_ad = ~addr; m_oe = 1'b1; nsync = 1'b0;
    @(negedge clk);
    if (op == 1) m_ad = ~wd; else m_oe = 1'b0;
    @(negedge clk);
    ndin = (op == 1); ndout = (op == 0); nwtbt = (op == 1) ? ~bw : 1'b1;
    for (int i = 1; i <= 12 && lat < 0; i++) begin
      @(negedge clk);
      if (nrply === 1'b0 || (!m_oe && nad !== 16'hFFFF)) drove = 1'b1;
      if (nrply === 1'b0) begin lat = i; rd = ~nad; end
    end
    m_oe = 1'b0; ndin = 1'b1; ndout = 1'b1; nwtbt = 1'b1;
    @(negedge clk);
    rel = (nrply === 1'b1) && (nad === 16'hFFFF);
    nsync = 1'b1;
    @(negedge clk);
    @(negedge clk);
    pulses = pulse_cnt;
  endtask
  task automatic test_reset;
    repeat (3) @(negedge clk);
    n_checks++; if (port_out !== 16'h0000) begin n_fail++; $display("FAIL reset port_out: got %h expected 0000", port_out); end
    n_checks++; if (sys_out !== SRST) begin n_fail++; $display("FAIL reset sys_out: got %h expected %h", sys_out, SRST); end
    n_checks++; if (port_wr !== 1'b0) begin n_fail++; $display("FAIL reset port_wr: got %b expected 0", port_wr); end
    n_checks++; if (nrply !== 1'b1) begin n_fail++; $display("FAIL reset nrply: got %b expected released", nrply); end
    n_checks++; if (nad !== 16'hFFFF) begin n_fail++; $display("FAIL reset nad: got %h expected released", nad); end
    nrst = 1'b1;
    repeat (2) @(negedge clk);
  endtask
  task automatic test_word_write;
    int lat, pulses; logic [15:0] rd; logic rel, drove;
    bus_cycle(A_PORT, 1, 1'b0, 16'h000F, lat, rd, pulses, rel, drove);
    port_m = 16'h000F;
    n_checks++; if (lat !== LAT) begin n_fail++; $display("FAIL word_write latency: got %0d expected %0d", lat, LAT); end
    n_checks++; if (port_out !== port_m) begin n_fail++; $display("FAIL word_write port_out: got %h expected %h", port_out, port_m); end
    n_checks++; if (pulses !== 1) begin n_fail++; $display("FAIL word_write port_wr pulses: got %0d expected 1", pulses); end
    n_checks++; if (rel !== 1'b1) begin n_fail++; $display("FAIL word_write release: got %b expected 1", rel); end
  endtask
  task automatic test_byte_write;
    int lat, pulses; logic [15:0] rd; logic rel, drove;
    bus_cycle(A_PORT + 16'd1, 1, 1'b1, 16'h5500, lat, rd, pulses, rel, drove);
    port_m = {8'h55, port_m[7:0]};
    n_checks++; if (port_out !== port_m) begin n_fail++; $display("FAIL byte_write_hi port_out: got %h expected %h", port_out, port_m); end
    n_checks++; if (pulses !== 1) begin n_fail++; $display("FAIL byte_write_hi pulses: got %0d expected 1", pulses); end
    bus_cycle(A_PORT, 1, 1'b1, 16'h0055, lat, rd, pulses, rel, drove);
    port_m = {port_m[15:8], 8'h55};
    n_checks++; if (port_out !== port_m) begin n_fail++; $display("FAIL byte_write_lo port_out: got %h expected %h", port_out, port_m); end
  endtask
  task automatic test_sys;
    int lat, pulses; logic [15:0] rd; logic rel, drove;
    bus_cycle(A_SYS, 1, 1'b0, 16'hFFFF, lat, rd, pulses, rel, drove);
    sys_m = (sys_m & ~MASK) | (16'hFFFF & MASK);
    n_checks++; if (sys_out !== sys_m) begin n_fail++; $display("FAIL sys_write sys_out: got %h expected %h", sys_out, sys_m); end
    n_checks++; if (pulses !== 0) begin n_fail++; $display("FAIL sys_write port_wr pulses: got %0d expected 0", pulses); end
    bus_cycle(A_SYS, 0, 1'b0, 16'h0000, lat, rd, pulses, rel, drove);
    n_checks++; if (rd !== sys_m) begin n_fail++; $display("FAIL sys_read data: got %h expected %h", rd, sys_m); end
    n_checks++; if (lat !== LAT) begin n_fail++; $display("FAIL sys_read latency: got %0d expected %0d", lat, LAT); end
    n_checks++; if (rel !== 1'b1) begin n_fail++; $display("FAIL sys_read release: got %b expected 1", rel); end
  endtask
  task automatic test_read_port;
    int lat, pulses; logic [15:0] rd; logic rel, drove;
    port_in = 16'hA5C3;
    bus_cycle(A_PORT, 0, 1'b1, 16'h0000, lat, rd, pulses, rel, drove);
    n_checks++; if (rd !== 16'hA5C3) begin n_fail++; $display("FAIL port_read data: got %h expected a5c3", rd); end
    n_checks++; if (port_out !== port_m) begin n_fail++; $display("FAIL port_read port_out: got %h expected %h", port_out, port_m); end
  endtask
  task automatic test_unmapped;
    int lat, pulses; logic [15:0] rd; logic rel, drove;
    bus_cycle(16'o177700, 1, 1'b0, 16'h1234, lat, rd, pulses, rel, drove);
    n_checks++; if (lat !== -1) begin n_fail++; $display("FAIL unmapped_write reply: got latency %0d expected none", lat); end
    n_checks++; if (port_out !== port_m || sys_out !== sys_m) begin n_fail++; $display("FAIL unmapped_write regs: got %h/%h expected %h/%h", port_out, sys_out, port_m, sys_m); end
    bus_cycle(16'o177700, 0, 1'b0, 16'h0000, lat, rd, pulses, rel, drove);
    n_checks++; if (drove !== 1'b0) begin n_fail++; $display("FAIL unmapped_read drove bus: got %b expected 0", drove); end
  endtask
  task automatic test_both_strobes;
    int lat, pulses; logic [15:0] rd; logic rel, drove;
    bus_cycle(A_SYS, 2, 1'b0, 16'h0000, lat, rd, pulses, rel, drove);
    n_checks++; if (rd !== sys_m) begin n_fail++; $display("FAIL both_strobes data: got %h expected %h", rd, sys_m); end
    n_checks++; if (sys_out !== sys_m) begin n_fail++; $display("FAIL both_strobes sys_out: got %h expected %h", sys_out, sys_m); end
  endtask
  task automatic test_abort;
    logic seen = 1'b0;
    @(negedge clk); m_ad = ~A_SYS; m_oe = 1'b1; nsync = 1'b0;
    @(negedge clk); m_ad = ~16'h0000;
    @(negedge clk); ndout = 1'b0; nsync = 1'b1;
    repeat (6) begin @(negedge clk); if (nrply === 1'b0) seen = 1'b1; end
    ndout = 1'b1; m_oe = 1'b0;
    @(negedge clk);
    n_checks++; if (seen !== 1'b0) begin n_fail++; $display("FAIL abort_waitstb reply: got %b expected 0", seen); end
    n_checks++; if (sys_out !== sys_m) begin n_fail++; $display("FAIL abort_waitstb sys_out: got %h expected %h", sys_out, sys_m); end
  endtask
`ifdef MPI_SLAVE_WAIT_EN
  task automatic test_dly_abort;
    logic seen = 1'b0;
    @(negedge clk); m_ad = ~A_SYS; m_oe = 1'b1; nsync = 1'b0;
    @(negedge clk); m_ad = ~16'h0000;
    @(negedge clk); ndout = 1'b0;
    @(negedge clk); ndout = 1'b1; m_oe = 1'b0;
    repeat (6) begin @(negedge clk); if (nrply === 1'b0) seen = 1'b1; end
    nsync = 1'b1;
    repeat (2) @(negedge clk);
    n_checks++; if (seen !== 1'b0) begin n_fail++; $display("FAIL dly_abort reply: got %b expected 0", seen); end
    n_checks++; if (sys_out !== sys_m) begin n_fail++; $display("FAIL dly_abort sys_out: got %h expected %h", sys_out, sys_m); end
  endtask
`endif
  task automatic test_random;
    int lat, pulses, sel, op, exp_lat, exp_pulses; logic [15:0] rd, addr, wd, exp_rd; logic rel, drove, bw, mapped, is_port;
    for (int n = 0; n < 40; n++) begin
      sel = $urandom_range(0, 4); op = $urandom_range(0, 1); bw = 1'($urandom); wd = 16'($urandom);
      port_in = 16'($urandom);
      mapped = sel < 2; is_port = sel == 0;
      addr = is_port ? A_PORT : A_SYS;
      if (mapped) addr[0] = 1'($urandom);
      else begin
        addr = 16'($urandom);
        if (addr[15:1] == A_PORT[15:1] || addr[15:1] == A_SYS[15:1]) addr = 16'o177700;
      end
      exp_rd = is_port ? port_in : sys_m;
      exp_lat = mapped ? LAT : -1;
      exp_pulses = (mapped && is_port && op == 1) ? 1 : 0;
      bus_cycle(addr, op, bw, wd, lat, rd, pulses, rel, drove);
      if (mapped && op == 1 && is_port) port_m = merge(port_m, addr[0], bw, wd);
      if (mapped && op == 1 && !is_port) sys_m = (sys_m & ~MASK) | (merge(sys_m, addr[0], bw, wd) & MASK);
      n_checks++; if (lat !== exp_lat) begin n_fail++; $display("FAIL random[%0d] latency: got %0d expected %0d", n, lat, exp_lat); end
      if (mapped && op == 0) begin
        n_checks++; if (rd !== exp_rd) begin n_fail++; $display("FAIL random[%0d] read: got %h expected %h", n, rd, exp_rd); end
      end
      n_checks++; if (port_out !== port_m) begin n_fail++; $display("FAIL random[%0d] port_out: got %h expected %h", n, port_out, port_m); end
      n_checks++; if (sys_out !== sys_m) begin n_fail++; $display("FAIL random[%0d] sys_out: got %h expected %h", n, sys_out, sys_m); end
      n_checks++; if (pulses !== exp_pulses) begin n_fail++; $display("FAIL random[%0d] pulses: got %0d expected %0d", n, pulses, exp_pulses); end
    end
  endtask
  task automatic test_reset_mid;
    int wait_n = 0;
    @(negedge clk); m_ad = ~A_SYS; m_oe = 1'b1; nsync = 1'b0;
    @(negedge clk); m_oe = 1'b0;
    @(negedge clk); ndin = 1'b0;
    while (nrply !== 1'b0 && wait_n < 12) begin @(negedge clk); wait_n++; end
    n_checks++; if (nrply !== 1'b0) begin n_fail++; $display("FAIL reset_mid no reply: got %b expected 0", nrply); end
    nrst = 1'b0;
    #1;
    port_m = 16'h0000; sys_m = SRST;
    n_checks++; if (nrply !== 1'b1) begin n_fail++; $display("FAIL reset_mid nrply: got %b expected released", nrply); end
    n_checks++; if (nad !== 16'hFFFF) begin n_fail++; $display("FAIL reset_mid nad: got %h expected released", nad); end
    n_checks++; if (sys_out !== sys_m) begin n_fail++; $display("FAIL reset_mid sys_out: got %h expected %h", sys_out, sys_m); end
    n_checks++; if (port_out !== port_m) begin n_fail++; $display("FAIL reset_mid port_out: got %h expected %h", port_out, port_m); end
    @(negedge clk); ndin = 1'b1; nsync = 1'b1;
    @(negedge clk); nrst = 1'b1;
    repeat (2) @(negedge clk);
  endtask
  initial begin
    test_reset;
    test_word_write;
    test_byte_write;
    test_sys;
    test_read_port;
    test_unmapped;
    test_both_strobes;
    test_abort;
`ifdef MPI_SLAVE_WAIT_EN
    test_dly_abort;
`endif
    test_random;
    test_reset_mid;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end
endmodule

// File: doc/mpi_reg_slave.md
Name: mpi_reg_slave

Overview:
- Clocked bus slave on the active-low multiplexed MPI bus (nAD/nSYNC/nDIN/nDOUT/nWTBT/nRPLY), directly downstream of the CPU bus master.
- Decodes two word registers and services read, word-write and byte-write cycles, generating open-drain nRPLY.
- PORT register at ADDR_PORT: writes go to port_out; reads return port_in.
- SYS register at ADDR_SYS: read/write, with a write mask.

Parameters:
- ADDR_PORT, 16'o177714, word address of the parallel port register.
- ADDR_SYS, 16'o177716, word address of the system register.
- SYS_WMASK, 16'hFFF0, bits of SYS writable from the bus; other bits hold their reset value.
- SYS_RESET, 16'h0000, reset value of SYS.
- WAIT_CYCLES, 2, extra CLKp cycles before nRPLY asserts (used only with the optional feature).

Ports:
- CLKp  input  1  bus clock; all state updates on the rising edge.
- nRSTp  input  1  asynchronous, active-low reset.
- nADp  inout  16  multiplexed address/data, inverted; driven only during a read reply, otherwise z.
- nSYNCp  input  1  active-low address strobe.
- nDINp  input  1  active-low read strobe.
- nDOUTp  input  1  active-low write strobe.
- nWTBTp  input  1  active-low; 0 during the data phase of a write means a byte write.
- nRPLYp  output  1  open-drain reply: drives 0 or z, never 1.
- port_in  input  16  value returned on a PORT read.
- port_out  output  16  PORT register contents.
- port_wr  output  1  one-cycle pulse after any PORT write.
- sys_out  output  16  SYS register contents.

Behaviour:
- Reset (async, nRSTp=0): port_out=0, sys_out=SYS_RESET, port_wr=0, nRPLYp=z, nADp=z, FSM=IDLE. Asserting reset mid-cycle releases nRPLYp and nADp immediately; no partial write commits.
- Bus levels are inverted. Internal address = ~nADp; write data = ~nADp; read data is driven as ~rdata.
- Edge detection: nSYNCp is registered each CLKp edge. A falling edge means previous sample 1 and current 0.
- FSM states: IDLE, ADDR, WAITSTB, DLY, REPLY, DONE.
- IDLE: on a falling nSYNCp, latch addr=~nADp, then go to ADDR.
- ADDR: sel_port = (addr[15:1]==ADDR_PORT[15:1]); sel_sys likewise. No match: go to DONE and never drive anything. Match: go to WAITSTB.
- WAITSTB: first cycle with nDINp=0 or nDOUTp=0 → DLY, or straight to REPLY when the delay is disabled.
  - Read: rdata captured in this cycle (port_in or sys_out).
  - Write: wdata=~nADp and byte=~nWTBTp captured in this cycle.
  - nDINp=0 and nDOUTp=0 together: treat as a read; do not write.
- REPLY, entry cycle:
  - nRPLYp=0 on entry. Read: nADp=~rdata on entry.
  - Write commits on the entry edge:
    - Word: reg = wdata.
    - Byte: addr[0]=0 updates bits [7:0] from wdata[7:0]; addr[0]=1 updates bits [15:8] from wdata[15:8].
    - SYS: only SYS_WMASK bits change.
    - PORT: port_wr=1 for exactly this one cycle.
  - Read latency: nRPLYp low on the second CLKp edge after nDINp is first sampled low (WAIT_CYCLES ignored).
- REPLY, hold/exit: hold nRPLYp and nADp while nDINp or nDOUTp is low. When both are sampled high, release nRPLYp and nADp on that edge and go to DONE.
- DONE: return to IDLE when nSYNCp is sampled high.
- nSYNCp sampled high in any state other than IDLE: abort to IDLE, release all drivers, discard any uncommitted write.
- A byte read drives the full word; the master selects the byte lane.
- Only one access per nSYNC assertion. A strobe re-asserted in DONE is ignored.

Optional Feature:
- Macro MPI_SLAVE_WAIT_EN.
- Defined: state DLY counts WAIT_CYCLES edges (counter width $clog2(WAIT_CYCLES+1)) before REPLY. Reply latency grows by WAIT_CYCLES. Strobe deassertion in DLY aborts to DONE with no write and no reply. WAIT_CYCLES=0 behaves as not defined.
- Not defined: DLY is never entered and the counter is not synthesized.

Test Plan:
- Word write to 177714, data 16'h000F (nWTBT high in the data phase) → nRPLYp low two edges after nDOUT falls; port_out=16'h000F; port_wr pulses exactly once; nRPLYp z after nDOUT rises.
- Byte write to 177715 (odd address) with data 16'h5500 → port_out[15:8]=8'h55, port_out[7:0] unchanged. Byte write to 177714 with data 16'h0055 → only the low byte becomes 8'h55.
- Word write 16'hFFFF to 177716 with SYS_RESET=0 → sys_out=16'hFFF0. Read 177716 → nADp=~16'hFFF0 while nRPLYp=0; both z after nDIN rises.
- Read 177714 with port_in=16'hA5C3 → nADp=~16'hA5C3. Access to 177700 → nRPLYp and nADp stay z for the whole cycle; no register changes.
- Reset mid-reply (nRSTp low while nRPLYp=0) → nRPLYp and nADp z immediately; sys_out=SYS_RESET. nSYNC rising while in WAITSTB → IDLE, no write.
- With MPI_SLAVE_WAIT_EN and WAIT_CYCLES=2 → nRPLYp falls two edges later than without it; nDOUT deasserted during DLY → no write, no reply.
